// File: rtl/ssd_pkg.sv
// Shared symbol codes, blink-field encodings and segment constants for the
// seven-segment display path; the lock ASM uses these same symbol codes.
package ssd_pkg;

    localparam logic [4:0] SYM_DASH  = 5'd16;
    localparam logic [4:0] SYM_BLANK = 5'd17;
    localparam logic [4:0] SYM_O     = 5'd18;
    localparam logic [4:0] SYM_P     = 5'd19;
    localparam logic [4:0] SYM_E     = 5'd20;
    localparam logic [4:0] SYM_N     = 5'd21;
    localparam logic [4:0] SYM_C     = 5'd22;
    localparam logic [4:0] SYM_L     = 5'd23;
    localparam logic [4:0] SYM_S     = 5'd24;
    localparam logic [4:0] SYM_D     = 5'd25;
    localparam logic [4:0] SYM_U     = 5'd26;
    localparam logic [4:0] SYM_R     = 5'd27;
    localparam logic [4:0] SYM_T     = 5'd28;
    localparam logic [4:0] SYM_Y     = 5'd29;

    // Blink field: MSB enables blinking, low two bits select 3 - digit
    localparam logic [2:0] BLINK_NONE = 3'b000;
    localparam logic [2:0] BLINK_D3   = 3'b100;
    localparam logic [2:0] BLINK_D2   = 3'b101;
    localparam logic [2:0] BLINK_D1   = 3'b110;
    localparam logic [2:0] BLINK_D0   = 3'b111;

    localparam logic [7:0] SEG_BLANK = 8'hFF;
    localparam logic [7:0] SEG_DASH  = 8'hBF;

endpackage

// File: rtl/ssd_symbol_decode.sv
// Maps a 5-bit symbol code to active-low {g,f,e,d,c,b,a} segment drive.
module ssd_symbol_decode
    import ssd_pkg::*;
(
    input  logic [4:0] sym,
    output logic [6:0] seg
);

    always_comb begin
        seg = 7'h7F;
        case (sym)
            5'd0:      seg = 7'h40;
            5'd1:      seg = 7'h79;
            5'd2:      seg = 7'h24;
            5'd3:      seg = 7'h30;
            5'd4:      seg = 7'h19;
            5'd5:      seg = 7'h12;
            5'd6:      seg = 7'h02;
            5'd7:      seg = 7'h78;
            5'd8:      seg = 7'h00;
            5'd9:      seg = 7'h10;
            5'd10:     seg = 7'h08;
            5'd11:     seg = 7'h03;
            5'd12:     seg = 7'h46;
            5'd13:     seg = 7'h21;
            5'd14:     seg = 7'h06;
            5'd15:     seg = 7'h0E;
            SYM_DASH:  seg = SEG_DASH[6:0];
            SYM_BLANK: seg = SEG_BLANK[6:0];
            SYM_O:     seg = 7'h40;
            SYM_P:     seg = 7'h0C;
            SYM_E:     seg = 7'h06;
            SYM_N:     seg = 7'h2B;
            SYM_C:     seg = 7'h46;
            SYM_L:     seg = 7'h47;
            SYM_S:     seg = 7'h12;
            SYM_D:     seg = 7'h21;
            SYM_U:     seg = 7'h63;
            SYM_R:     seg = 7'h2F;
            SYM_T:     seg = 7'h07;
            SYM_Y:     seg = 7'h11;
            default:   seg = 7'h7F;
        endcase
    end

endmodule

// File: rtl/ssd_disp_driver.sv
// Scans four symbol codes onto a 4-digit common-anode SSD, blanking the
// selected digit at the blink rate. Outputs are registered.
module ssd_disp_driver
    import ssd_pkg::*;
#(
    parameter int unsigned REFRESH_DIV = 100000,
    parameter int unsigned BLINK_DIV   = 50000000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [22:0] disps,
    output logic [3:0]  AN,
    output logic [7:0]  seven_out
);

    localparam int unsigned RW = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
    localparam int unsigned BW = (BLINK_DIV > 1) ? $clog2(BLINK_DIV) : 1;
    localparam logic [RW-1:0] REFRESH_LAST = RW'(REFRESH_DIV - 1);
    localparam logic [BW-1:0] BLINK_LAST   = BW'(BLINK_DIV - 1);

    logic [RW-1:0] refresh_cnt;
    logic [BW-1:0] blink_cnt;
    logic [1:0]    idx;
    logic          blink_off;

    logic [4:0]    sym;
    logic [6:0]    seg;
    logic [1:0]    blink_digit;
    logic          blank_slot;

    always_comb begin
        sym = disps[4:0];
        case (idx)
            2'd0: sym = disps[4:0];
            2'd1: sym = disps[9:5];
            2'd2: sym = disps[14:10];
            2'd3: sym = disps[19:15];
            default: sym = disps[4:0];
        endcase
        blink_digit = 2'd3 - disps[21:20];
        blank_slot  = disps[22] && (idx == blink_digit) && blink_off;
    end

    ssd_symbol_decode u_decode (
        .sym (sym),
        .seg (seg)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            refresh_cnt <= '0;
            blink_cnt   <= '0;
            idx         <= '0;
            blink_off   <= 1'b0;
            AN          <= '1;
            seven_out   <= SEG_BLANK;
        end else begin
            if (refresh_cnt == REFRESH_LAST) begin
                refresh_cnt <= '0;
                idx         <= idx + 2'd1;
            end else begin
                refresh_cnt <= refresh_cnt + 1'b1;
            end

            if (blink_cnt == BLINK_LAST) begin
                blink_cnt <= '0;
                blink_off <= ~blink_off;
            end else begin
                blink_cnt <= blink_cnt + 1'b1;
            end

            if (blank_slot) begin
                AN        <= '1;
                seven_out <= SEG_BLANK;
            end else begin
                AN        <= ~(4'b0001 << idx);
                seven_out <= {1'b1, seg};
            end
        end
    end

endmodule

// File: tb/tb_ssd_disp_driver.sv
// Self-checking bench for ssd_disp_driver with short dividers; expected
// outputs come from a cycle-index model of scan slot and blink phase.
module tb_ssd_disp_driver;
    import ssd_pkg::*;

    localparam int unsigned RD = 4;
    localparam int unsigned BD = 32;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [22:0] disps = '0;
    logic [3:0]  AN;
    logic [7:0]  seven_out;

    int unsigned n_cmp = 0;
    int unsigned n_bad = 0;
    int unsigned k = 0;   // non-reset edges since the last reset edge

    always #5 clk = ~clk;

    ssd_disp_driver #(.REFRESH_DIV(RD), .BLINK_DIV(BD)) dut (
        .clk       (clk),
        .rst       (rst),
        .disps     (disps),
        .AN        (AN),
        .seven_out (seven_out)
    );

    localparam logic [6:0] SEG_TAB [32] = '{
        7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
        7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E,
        7'h3F, 7'h7F, 7'h40, 7'h0C, 7'h06, 7'h2B, 7'h46, 7'h47,
        7'h12, 7'h21, 7'h63, 7'h2F, 7'h07, 7'h11, 7'h7F, 7'h7F};

    // Outputs after the edge numbered kk, given disps present at that edge
    function automatic logic [11:0] model(input int unsigned kk, input logic [22:0] d);
        int unsigned slot;
        int unsigned code;
        bit          boff;
        logic [22:0] sh;
        logic [3:0]  an;
        slot = (kk / RD) % 4;
        boff = ((kk / BD) % 2) == 1;
        sh   = d >> (5 * slot);
        code = int'(sh[4:0]);
        if (d[22] && (slot == 3 - int'(d[21:20])) && boff)
            return {4'hF, 8'hFF};
        an = ~(4'b0001 << slot);
        return {an, 1'b1, SEG_TAB[code]};
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
        if (rst) k = 0;
        else     k = k + 1;
    endtask

    task automatic test_reset();
        logic [7:0] scan_seg [4];
        logic [3:0] an;
        scan_seg = '{8'hA1, 8'h92, 8'hC7, 8'hC6};
        rst   = 1'b1;
        disps = {BLINK_NONE, SYM_C, SYM_L, SYM_S, SYM_D};
        repeat (3) begin
            tick();
            n_cmp++;
            if (AN !== 4'hF || seven_out !== 8'hFF) begin
                n_bad++;
                $display("FAIL reset got AN=%b seven=%h want AN=1111 seven=ff", AN, seven_out);
            end
        end
        rst = 1'b0;
        for (int j = 0; j < 32; j++) begin
            tick();
            an = ~(4'b0001 << ((j / 4) % 4));
            n_cmp++;
            if (AN !== an || seven_out !== scan_seg[(j / 4) % 4]) begin
                n_bad++;
                $display("FAIL scan j=%0d got AN=%b seven=%h want AN=%b seven=%h",
                         j, AN, seven_out, an, scan_seg[(j / 4) % 4]);
            end
        end
    endtask

    task automatic test_blink(input string name, input logic [22:0] d, input int unsigned cycles);
        logic [11:0] e;
        int unsigned kk;
        disps = d;
        for (int unsigned j = 0; j < cycles; j++) begin
            kk = k;
            e  = model(kk, disps);
            tick();
            n_cmp++;
            if ({AN, seven_out} !== e) begin
                n_bad++;
                $display("FAIL %s k=%0d got AN=%b seven=%h want AN=%b seven=%h",
                         name, kk, AN, seven_out, e[11:8], e[7:0]);
            end
        end
    endtask

    task automatic test_invalid_codes();
        logic [11:0] e;
        int unsigned kk;
        for (int j = 0; j < 64; j++) begin
            if (j % 8 == 0)
                disps = {3'b000, 5'd30 + 5'($urandom_range(0, 1)), 5'd30 + 5'($urandom_range(0, 1)),
                         5'd30 + 5'($urandom_range(0, 1)), 5'd30 + 5'($urandom_range(0, 1))};
            kk = k;
            e  = model(kk, disps);
            tick();
            n_cmp++;
            if ($isunknown({AN, seven_out}) || seven_out !== 8'hFF || {AN, seven_out} !== e) begin
                n_bad++;
                $display("FAIL invalid_code k=%0d got AN=%b seven=%h want AN=%b seven=ff",
                         kk, AN, seven_out, e[11:8]);
            end
        end
    endtask

    task automatic test_mid_reset();
        int unsigned guard = 0;
        disps = {BLINK_D0, SYM_DASH, SYM_DASH, SYM_DASH, 5'd5};
        while (!(((k / RD) % 4) == 2 && ((k / BD) % 2) == 1) && guard < 200) begin
            tick();
            guard++;
        end
        n_cmp++;
        if (guard >= 200) begin
            n_bad++;
            $display("FAIL mid_reset_reach k=%0d got no slot2/blink_off window want one", k);
        end
        rst = 1'b1;
        tick();
        n_cmp++;
        if (AN !== 4'hF || seven_out !== 8'hFF) begin
            n_bad++;
            $display("FAIL mid_reset_dark got AN=%b seven=%h want AN=1111 seven=ff", AN, seven_out);
        end
        rst = 1'b0;
        for (int j = 0; j < 4; j++) begin
            tick();
            n_cmp++;
            if (AN !== 4'b1110 || seven_out !== 8'h92) begin
                n_bad++;
                $display("FAIL mid_reset_restart j=%0d got AN=%b seven=%h want AN=1110 seven=92",
                         j, AN, seven_out);
            end
        end
    endtask

    task automatic test_disps_change();
        int unsigned guard = 0;
        disps = {BLINK_NONE, 5'd1, 5'd2, 5'd3, 5'd4};
        while (!(((k / RD) % 4) == 1 && (k % RD) == 1) && guard < 50) begin
            tick();
            guard++;
        end
        n_cmp++;
        if (AN !== 4'b1101 || seven_out !== 8'hB0) begin
            n_bad++;
            $display("FAIL change_before got AN=%b seven=%h want AN=1101 seven=b0", AN, seven_out);
        end
        disps = {BLINK_NONE, 5'd1, 5'd2, 5'd8, 5'd4};
        tick();
        n_cmp++;
        if (AN !== 4'b1101 || seven_out !== 8'h80) begin
            n_bad++;
            $display("FAIL change_after got AN=%b seven=%h want AN=1101 seven=80", AN, seven_out);
        end
    endtask

    task automatic test_random();
        logic [11:0] e;
        int unsigned kk;
        for (int j = 0; j < 300; j++) begin
            if ($urandom_range(0, 5) == 0) disps = 23'($urandom);
            kk = k;
            e  = model(kk, disps);
            tick();
            n_cmp++;
            if ({AN, seven_out} !== e) begin
                n_bad++;
                $display("FAIL random k=%0d disps=%h got AN=%b seven=%h want AN=%b seven=%h",
                         kk, disps, AN, seven_out, e[11:8], e[7:0]);
            end
        end
    endtask

    initial begin
        test_reset();
        test_blink("blink3", {BLINK_D3, 5'd7, SYM_BLANK, SYM_BLANK, SYM_BLANK}, 128);
        test_blink("blink0", {BLINK_D0, SYM_DASH, SYM_DASH, SYM_DASH, 5'd5}, 128);
        test_invalid_codes();
        test_mid_reset();
        test_disps_change();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
